// File: rtl/start_pulse_recover.sv
// Qualifies a stretched, asynchronous start level into a single-cycle start strobe,
// with glitch rejection, an over-long window flag and a low-gap re-arm rule.
module start_pulse_recover #(
  parameter int MIN_WIDTH = 4,
  parameter int MAX_WIDTH = 64,
  parameter int GAP       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_data,
  output logic       start_pulse,
  output logic       start_err,
  output logic       busy,
  output logic [7:0] start_count
);

  typedef enum logic [1:0] {IDLE, QUALIFY, HIGH_WAIT, LOW_GAP} state_t;

  localparam logic [6:0] MIN_W = 7'(MIN_WIDTH);
  localparam logic [6:0] MAX_W = 7'(MAX_WIDTH);
  localparam logic [6:0] GAP_W = 7'(GAP);
  localparam logic [6:0] W_SAT = 7'd127;

  state_t     state_q, state_d;
  logic       q1_q, q2_q;
  logic [6:0] wcnt_q, wcnt_d;
  logic [6:0] gcnt_q, gcnt_d;
  logic       start_pulse_q, start_pulse_d;
  logic       start_err_q, start_err_d;
  logic [7:0] start_count_q, start_count_d;
  logic       s;

  assign s = q2_q;

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    gcnt_d        = gcnt_q;
    start_pulse_d = 1'b0;
    start_err_d   = 1'b0;
    start_count_d = start_count_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = QUALIFY;
          wcnt_d  = 7'd1;
        end
      end
      QUALIFY: begin
        if (!s) begin
          state_d = IDLE;
          wcnt_d  = 7'd0;
        end else if (wcnt_q + 7'd1 == MIN_W) begin
          state_d       = HIGH_WAIT;
          wcnt_d        = wcnt_q + 7'd1;
          start_pulse_d = 1'b1;
          start_count_d = start_count_q + 8'd1;
        end else begin
          wcnt_d = wcnt_q + 7'd1;
        end
      end
      HIGH_WAIT: begin
        if (s) begin
          // Saturation keeps the MAX_W -> MAX_W+1 step from recurring in one window.
          if (wcnt_q != W_SAT) begin
            wcnt_d = wcnt_q + 7'd1;
          end
          if (wcnt_q == MAX_W) begin
            start_err_d = 1'b1;
          end
        end else begin
          state_d = LOW_GAP;
          gcnt_d  = 7'd1;
          wcnt_d  = 7'd0;
        end
      end
      LOW_GAP: begin
        if (s) begin
          gcnt_d = 7'd0;
        end else if (gcnt_q + 7'd1 == GAP_W) begin
          state_d = IDLE;
          gcnt_d  = 7'd0;
        end else begin
          gcnt_d = gcnt_q + 7'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 7'd0;
        gcnt_d  = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q          <= 1'b0;
      q2_q          <= 1'b0;
      state_q       <= IDLE;
      wcnt_q        <= 7'd0;
      gcnt_q        <= 7'd0;
      start_pulse_q <= 1'b0;
      start_err_q   <= 1'b0;
      start_count_q <= 8'd0;
    end else begin
      q1_q          <= start_data;
      q2_q          <= q1_q;
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      gcnt_q        <= gcnt_d;
      start_pulse_q <= start_pulse_d;
      start_err_q   <= start_err_d;
      start_count_q <= start_count_d;
    end
  end

  assign start_pulse = start_pulse_q;
  assign start_err   = start_err_q;
  assign busy        = (state_q != IDLE);
  assign start_count = start_count_q;

endmodule

// File: tb/tb_start_pulse_recover.sv
// Bench for start_pulse_recover: directed windows plus random windows, all checked
// every cycle against a run-length model of the acceptance rules.
module tb_start_pulse_recover;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;
  localparam int GAP       = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_data;
  logic       start_pulse;
  logic       start_err;
  logic       busy;
  logic [7:0] start_count;

  int tests_run    = 0;
  int tests_failed = 0;

  int pulses_seen, errs_seen, edge_idx, last_pulse_idx, last_err_idx;

  // Model: a two-deep sample delay, then rules expressed as run lengths of
  // consecutive high/low samples and an "armed" flag for the re-arm gap.
  bit m_q1, m_q2, m_armed, m_win_ok;
  int m_high, m_low, m_count;
  bit e_pulse, e_err, e_busy;

  start_pulse_recover #(
    .MIN_WIDTH(MIN_WIDTH),
    .MAX_WIDTH(MAX_WIDTH),
    .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_data(start_data),
    .start_pulse(start_pulse),
    .start_err(start_err),
    .busy(busy),
    .start_count(start_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_q1 = 0; m_q2 = 0; m_armed = 1; m_win_ok = 0;
    m_high = 0; m_low = 0; m_count = 0;
    e_pulse = 0; e_err = 0; e_busy = 0;
  endtask

  task automatic modelStep(input bit s);
    e_pulse = 0;
    e_err   = 0;
    if (s) begin
      m_low = 0;
      m_high++;
      if (m_high == 1) m_win_ok = m_armed;
      if (m_win_ok && m_high == MIN_WIDTH) begin
        e_pulse = 1;
        m_count = (m_count + 1) % 256;
        m_armed = 0;
      end
      if (m_win_ok && m_high == MAX_WIDTH + 1) e_err = 1;
    end else begin
      m_high   = 0;
      m_win_ok = 0;
      if (!m_armed) begin
        m_low++;
        if (m_low == GAP) m_armed = 1;
      end
    end
    e_busy = !m_armed || (s && m_win_ok);
  endtask

  task automatic applyStimulus(input bit d, input string tag);
    bit s_used;
    start_data = d;
    @(posedge clk);
    edge_idx++;
    if (rst_n) begin
      s_used = m_q2;
      m_q2   = m_q1;
      m_q1   = d;
      modelStep(s_used);
    end
    #1;
    if (start_pulse === 1'b1) begin pulses_seen++; last_pulse_idx = edge_idx; end
    if (start_err === 1'b1) begin errs_seen++; last_err_idx = edge_idx; end
    checkOutput({tag, ".pulse"}, 32'(start_pulse), 32'(e_pulse));
    checkOutput({tag, ".err"},   32'(start_err),   32'(e_err));
    checkOutput({tag, ".busy"},  32'(busy),        32'(e_busy));
    checkOutput({tag, ".count"}, 32'(start_count), 32'(m_count));
  endtask

  task automatic runLevel(input bit d, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(d, tag);
  endtask

  task automatic clearStats();
    pulses_seen = 0; errs_seen = 0; edge_idx = 0;
    last_pulse_idx = -1; last_err_idx = -1;
  endtask

  initial begin
    start_data = 1'b0;
    rst_n      = 1'b0;
    modelReset();
    clearStats();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.pulse", 32'(start_pulse), 0);
    checkOutput("reset.err",   32'(start_err),   0);
    checkOutput("reset.busy",  32'(busy),        0);
    checkOutput("reset.count", 32'(start_count), 0);
    rst_n = 1'b1;
    runLevel(0, 5, "idle");

    // Nominal 58-cycle window
    clearStats();
    runLevel(1, 58, "nominal");
    runLevel(0, 10, "nominal");
    checkOutput("nominal.npulse",  pulses_seen, 1);
    checkOutput("nominal.latency", last_pulse_idx, MIN_WIDTH + 2);
    checkOutput("nominal.nerr",    errs_seen, 0);
    checkOutput("nominal.final",   32'(start_count), 1);

    // Glitch shorter than MIN_WIDTH
    clearStats();
    runLevel(1, MIN_WIDTH - 1, "glitch");
    runLevel(0, 10, "glitch");
    checkOutput("glitch.npulse", pulses_seen, 0);

    // Exactly MIN_WIDTH is accepted
    clearStats();
    runLevel(1, MIN_WIDTH, "minw");
    runLevel(0, 10, "minw");
    checkOutput("minw.npulse", pulses_seen, 1);

    // Stuck high
    clearStats();
    runLevel(1, 100, "stuck");
    runLevel(0, 10, "stuck");
    checkOutput("stuck.npulse", pulses_seen, 1);
    checkOutput("stuck.nerr",   errs_seen, 1);
    checkOutput("stuck.errpos", last_err_idx, MAX_WIDTH + 3);

    // Window boundaries at MAX_WIDTH and MAX_WIDTH+1
    clearStats();
    runLevel(1, MAX_WIDTH, "max64");
    runLevel(0, 10, "max64");
    checkOutput("max64.nerr", errs_seen, 0);
    clearStats();
    runLevel(1, MAX_WIDTH + 1, "max65");
    runLevel(0, 10, "max65");
    checkOutput("max65.nerr", errs_seen, 1);

    // Gap too short: second window swallowed
    clearStats();
    runLevel(1, 58, "gap2");
    runLevel(0, 2, "gap2");
    runLevel(1, 58, "gap2");
    runLevel(0, 10, "gap2");
    checkOutput("gap2.npulse", pulses_seen, 1);

    // Gap exactly GAP: both windows accepted
    clearStats();
    runLevel(1, 58, "gap4");
    runLevel(0, GAP, "gap4");
    runLevel(1, 58, "gap4");
    runLevel(0, 10, "gap4");
    checkOutput("gap4.npulse", pulses_seen, 2);

    // Async reset in the middle of a window
    runLevel(1, 20, "rstmid");
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.now.pulse", 32'(start_pulse), 0);
    checkOutput("rstmid.now.err",   32'(start_err),   0);
    checkOutput("rstmid.now.busy",  32'(busy),        0);
    checkOutput("rstmid.now.count", 32'(start_count), 0);
    modelReset();
    runLevel(1, 9, "rstheld");
    rst_n = 1'b1;
    clearStats();
    runLevel(1, 28, "rstrel");
    runLevel(0, 10, "rstrel");
    checkOutput("rstrel.npulse",  pulses_seen, 1);
    checkOutput("rstrel.latency", last_pulse_idx, MIN_WIDTH + 2);
    checkOutput("rstrel.final",   32'(start_count), 1);

    // Counter wrap after 256 accepted windows from reset
    rst_n = 1'b0;
    modelReset();
    runLevel(0, 2, "wrapreset");
    rst_n = 1'b1;
    clearStats();
    for (int w = 1; w <= 256; w++) begin
      runLevel(1, 10, "wrap");
      runLevel(0, 6, "wrap");
      if (w == 255) checkOutput("wrap.at255", 32'(start_count), 255);
      if (w == 256) checkOutput("wrap.at256", 32'(start_count), 0);
    end
    checkOutput("wrap.npulse", pulses_seen, 256);

    // Random windows checked by the model every cycle
    for (int r = 0; r < 30; r++) begin
      runLevel(1, $urandom_range(1, 80), "rand");
      runLevel(0, $urandom_range(1, 8), "rand");
    end
    runLevel(0, 10, "rand");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
